// File: rtl/gpio_pkg.sv
// Shared GPIO register definitions: offsets for the input conditioner window
// and a decode helper used by the conditioner's register logic.
package gpio_pkg;

    localparam logic [3:0] GPIO_IC_RISE_EN = 4'h0;
    localparam logic [3:0] GPIO_IC_FALL_EN = 4'h4;
    localparam logic [3:0] GPIO_IC_STATUS  = 4'h8;
    localparam logic [3:0] GPIO_IC_CLEAN   = 4'hC;

    typedef struct packed {
        logic rise_en;
        logic fall_en;
        logic status;
        logic clean;
    } gpio_ic_sel_t;

    // One-hot register select; unmapped addresses select nothing.
    function automatic gpio_ic_sel_t gpio_ic_decode(input logic [3:0] addr);
        gpio_ic_sel_t sel;
        sel = '{rise_en: 1'b0, fall_en: 1'b0, status: 1'b0, clean: 1'b0};
        case (addr)
            GPIO_IC_RISE_EN: sel.rise_en = 1'b1;
            GPIO_IC_FALL_EN: sel.fall_en = 1'b1;
            GPIO_IC_STATUS:  sel.status  = 1'b1;
            GPIO_IC_CLEAN:   sel.clean   = 1'b1;
            default:         sel = '{rise_en: 1'b0, fall_en: 1'b0, status: 1'b0, clean: 1'b0};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Register bus of the input conditioner, same we/re/addr/wdata/rdata style
// as gpio_control_ip.
interface gpio_input_conditioner_if;

    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output re,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  re,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// Single-bit pad conditioner: 2-flop synchroniser feeding a counter that only
// lets the clean value follow after DEBOUNCE_CYCLES consecutive differing samples.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic clean
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchroniser for the asynchronous pad level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pad;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter; any sample agreeing with clean restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            clean_r <= 1'b0;
        end else if (sync2_r == clean_r) begin
            cnt_r   <= {CNT_W{1'b0}};
            clean_r <= clean_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            clean_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            clean_r <= clean_r;
        end
    end

    assign clean = clean_r;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Pad input conditioner: per-bit synchronise + debounce, edge detection into
// sticky W1C status with a level interrupt, and a small register window.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           pad_in,
    gpio_input_conditioner_if.slave    bus,
    output logic [WIDTH-1:0]           gpio_in_clean,
    output logic                       irq
);

    logic [WIDTH-1:0] clean_s;
    logic [WIDTH-1:0] clean_d_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [WIDTH-1:0] status_r;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [31:0]      rdata_s;
    gpio_ic_sel_t     sel_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .pad   (pad_in[i]),
            .clean (clean_s[i])
        );
    end

    assign sel_s   = gpio_ic_decode(bus.addr);
    assign wdata_s = bus.wdata[WIDTH-1:0];

    // Edge events and W1C mask; a set in the same cycle as a clear wins.
    always_comb begin
        rise_s = clean_s & ~clean_d_r;
        fall_s = ~clean_s & clean_d_r;
        set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);
        if (bus.we && sel_s.status) begin
            clr_s = wdata_s;
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Edge-detect delay and sticky status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_d_r <= {WIDTH{1'b0}};
            status_r  <= {WIDTH{1'b0}};
        end else begin
            clean_d_r <= clean_s;
            status_r  <= (status_r & ~clr_s) | set_s;
        end
    end

    // Enable registers; writes to unmapped addresses fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_en_r <= {WIDTH{1'b0}};
            fall_en_r <= {WIDTH{1'b0}};
        end else if (bus.we && sel_s.rise_en) begin
            rise_en_r <= wdata_s;
        end else if (bus.we && sel_s.fall_en) begin
            fall_en_r <= wdata_s;
        end else begin
            rise_en_r <= rise_en_r;
            fall_en_r <= fall_en_r;
        end
    end

    // Combinational read mux, zero whenever the read strobe is low.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!bus.re) begin
            rdata_s = 32'h0000_0000;
        end else if (sel_s.rise_en) begin
            rdata_s = 32'(rise_en_r);
        end else if (sel_s.fall_en) begin
            rdata_s = 32'(fall_en_r);
        end else if (sel_s.status) begin
            rdata_s = 32'(status_r);
        end else if (sel_s.clean) begin
            rdata_s = 32'(clean_s);
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata     = rdata_s;
    assign gpio_in_clean = clean_s;
    assign irq           = |status_r;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;

    logic       clk;
    logic       reset;
    logic [7:0] pad_in;
    logic [7:0] gpio_in_clean;
    logic       irq;

    gpio_input_conditioner_if bus_if ();

    gpio_input_conditioner #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pad_in        (pad_in),
        .bus           (bus_if),
        .gpio_in_clean (gpio_in_clean),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", obs, 32'hDEAD_BEEF);
        end else begin
            check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        tick(1);
        bus_if.we    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_if.re   = 1'b1;
        bus_if.addr = a;
        #1;
        d = bus_if.rdata;
        bus_if.re   = 1'b0;
    endtask

    logic [31:0] rd;
    bit          found;

    initial begin
        reset        = 1'b1;
        pad_in       = 8'h00;
        bus_if.we    = 1'b0;
        bus_if.re    = 1'b0;
        bus_if.addr  = 4'h0;
        bus_if.wdata = 32'h0000_0000;
        tick(3);

        // Reset behaviour
        sb_push("rst_clean", 32'h0);
        sb_check(32'(gpio_in_clean));
        reset = 1'b0;
        bus_write(4'h0, 32'h0000_00FF);
        pad_in = 8'hFF;
        tick(7);
        sb_push("pre_rst_irq", 32'h1);
        sb_check(32'(irq));
        #2;
        reset = 1'b1;
        #1;
        sb_push("mid_rst_clean", 32'h0);
        sb_check(32'(gpio_in_clean));
        sb_push("mid_rst_irq", 32'h0);
        sb_check(32'(irq));
        tick(2);
        reset = 1'b0;
        bus_read(4'h0, rd);
        sb_push("rst_rise_en", 32'h0);
        sb_check(rd);
        tick(5);
        sb_push("rel_edge5", 32'h00);
        sb_check(32'(gpio_in_clean));
        tick(1);
        sb_push("rel_edge6", 32'hFF);
        sb_check(32'(gpio_in_clean));

        // Glitch reject
        pad_in = 8'h00;
        tick(6);
        sb_push("settle_low", 32'h00);
        sb_check(32'(gpio_in_clean));
        pad_in = 8'h01;
        tick(3);
        pad_in = 8'h00;
        tick(10);
        sb_push("glitch_clean", 32'h00);
        sb_check(32'(gpio_in_clean));
        bus_read(4'hC, rd);
        sb_push("glitch_rd_clean", 32'h0);
        sb_check(rd);

        // Rising interrupt
        bus_write(4'h0, 32'h0000_0001);
        pad_in = 8'h01;
        tick(5);
        sb_push("rise_edge5", 32'h00);
        sb_check(32'(gpio_in_clean));
        tick(1);
        sb_push("rise_edge6", 32'h01);
        sb_check(32'(gpio_in_clean));
        bus_read(4'h8, rd);
        sb_push("rise_stat6", 32'h0);
        sb_check(rd);
        tick(1);
        bus_read(4'h8, rd);
        sb_push("rise_stat7", 32'h1);
        sb_check(rd);
        sb_push("rise_irq7", 32'h1);
        sb_check(32'(irq));
        bus_write(4'h8, 32'h0000_0001);
        bus_read(4'h8, rd);
        sb_push("w1c_stat", 32'h0);
        sb_check(rd);
        sb_push("w1c_irq", 32'h0);
        sb_check(32'(irq));

        // Falling only on bit 7
        bus_write(4'h4, 32'h0000_0080);
        bus_write(4'h0, 32'h0000_0000);
        pad_in = 8'h81;
        tick(10);
        bus_read(4'h8, rd);
        sb_push("fall_after_rise", 32'h0);
        sb_check(rd);
        pad_in = 8'h01;
        tick(10);
        bus_read(4'h8, rd);
        sb_push("fall_after_fall", 32'h80);
        sb_check(rd);
        sb_push("fall_irq", 32'h1);
        sb_check(32'(irq));
        bus_write(4'h8, 32'hFFFF_FFFF);

        // Set/clear collision on bit 0
        bus_write(4'h0, 32'h0000_0001);
        pad_in = 8'h00;
        tick(10);
        bus_read(4'h8, rd);
        sb_push("coll_pre_stat", 32'h0);
        sb_check(rd);
        pad_in = 8'h01;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (gpio_in_clean[0]) found = 1'b1;
        end
        sb_push("coll_wait", 32'h1);
        sb_check(32'(found));
        bus_write(4'h8, 32'h0000_0001);
        bus_read(4'h8, rd);
        sb_push("coll_stat", 32'h1);
        sb_check(rd);
        sb_push("coll_irq", 32'h1);
        sb_check(32'(irq));
        bus_write(4'h0, 32'h0000_0000);
        bus_read(4'h8, rd);
        sb_push("dis_keeps_stat", 32'h1);
        sb_check(rd);

        // Bus edges
        bus_write(4'h0, 32'hFFFF_FFFF);
        bus_read(4'h0, rd);
        sb_push("rise_en_mask", 32'h0000_00FF);
        sb_check(rd);
        bus_write(4'h5, 32'h1234_5678);
        bus_read(4'h0, rd);
        sb_push("bad_wr_rise", 32'h0000_00FF);
        sb_check(rd);
        bus_read(4'h4, rd);
        sb_push("bad_wr_fall", 32'h0000_0080);
        sb_check(rd);
        bus_read(4'h8, rd);
        sb_push("bad_wr_stat", 32'h0000_0001);
        sb_check(rd);
        bus_read(4'h5, rd);
        sb_push("bad_rd", 32'h0);
        sb_check(rd);
        bus_read(4'hC, rd);
        sb_push("rd_clean", 32'h01);
        sb_check(rd);
        for (int a = 0; a < 16; a++) begin
            bus_if.re   = 1'b0;
            bus_if.addr = 4'(a);
            #1;
            sb_push($sformatf("re0_a%0d", a), 32'h0);
            sb_check(bus_if.rdata);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
